// File: rtl/ymc_control_if.sv
// Bundle between the multicycle control unit and the yIF/yID/yEX/yDM/yWB datapath.
// mem_ready: the data memory drives it high in the cycle an access completes; it is only sampled in MEM.
interface ymc_control_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      ins;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite;
  logic [1:0]       pc_sel;
  logic             IRWrite;
  logic             RegWrite;
  logic             ALUSrc;
  logic [1:0]       wb_sel;
  logic             MemRead;
  logic             MemWrite;
  logic [2:0]       op;
  logic [2:0]       state;
  logic             illegal;
  logic             timeout;
  logic [CNT_W-1:0] instret;

  modport master (
    input  ins, zero, mem_ready,
    output PCWrite, pc_sel, IRWrite, RegWrite, ALUSrc, wb_sel,
           MemRead, MemWrite, op, state, illegal, timeout, instret
  );

  modport slave (
    output ins, zero, mem_ready,
    input  PCWrite, pc_sel, IRWrite, RegWrite, ALUSrc, wb_sel,
           MemRead, MemWrite, op, state, illegal, timeout, instret
  );
endinterface

// File: rtl/ymc_control.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory-wait timeout,
// sticky illegal/timeout flags and a retired-instruction counter.
module ymc_control #(
  parameter int CNT_W           = 32,
  parameter int TMO_W           = 4,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  ymc_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_R     = 7'h33;
  localparam logic [6:0] OPC_I     = 7'h13;
  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_BEQ   = 7'h63;
  localparam logic [6:0] OPC_JAL   = 7'h6F;

  // Last wait count before saturation; a miss here is the final allowed wait cycle.
  localparam logic [TMO_W-1:0] WAIT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state_q, state_d;
  logic [6:0]       opc_q, opc_d;
  logic [2:0]       f3_q, f3_d;
  logic             f7b5_q, f7b5_d;
  logic [TMO_W-1:0] wait_q, wait_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic       pc_write, ir_write, reg_write, alu_src, mem_read, mem_write, retire;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] alu_op;
  logic       is_load, is_store, is_beq, is_jal, is_r;

  logic unused_ins;
  assign unused_ins = ^{bus.ins[31], bus.ins[29:15], bus.ins[11:7]};

  function automatic logic opc_legal(input logic [6:0] o);
    return (o == OPC_R) || (o == OPC_I) || (o == OPC_LOAD) ||
           (o == OPC_STORE) || (o == OPC_BEQ) || (o == OPC_JAL);
  endfunction

  function automatic logic [2:0] alu_map(input logic [6:0] o, input logic [2:0] f3,
                                         input logic f7b5);
    logic [2:0] r;
    r = 3'b010;
    if (o == OPC_BEQ) begin
      r = 3'b110;
    end else if ((o == OPC_R) || (o == OPC_I)) begin
      case (f3)
        3'b000:  r = ((o == OPC_R) && f7b5) ? 3'b110 : 3'b010;
        3'b111:  r = 3'b000;
        3'b110:  r = 3'b001;
        3'b010:  r = 3'b111;
        default: r = 3'b010;
      endcase
    end
    return r;
  endfunction

  assign is_load  = (opc_q == OPC_LOAD);
  assign is_store = (opc_q == OPC_STORE);
  assign is_beq   = (opc_q == OPC_BEQ);
  assign is_jal   = (opc_q == OPC_JAL);
  assign is_r     = (opc_q == OPC_R);

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    f3_d      = f3_q;
    f7b5_d    = f7b5_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    instret_d = instret_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    alu_src   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    retire    = 1'b0;
    pc_sel    = 2'd0;
    wb_sel    = 2'd0;
    alu_op    = 3'd0;

    // ALU controls only matter once the opcode fields have been latched.
    if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
      alu_op  = alu_map(opc_q, f3_q, f7b5_q);
      alu_src = !(is_r || is_beq);
    end

    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        opc_d  = bus.ins[6:0];
        f3_d   = bus.ins[14:12];
        f7b5_d = bus.ins[30];
        if (opc_legal(bus.ins[6:0])) begin
          state_d = S_EXEC;
        end else if (HALT_ON_ILLEGAL) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          pc_write = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          pc_write = 1'b1;
          pc_sel   = bus.zero ? 2'd1 : 2'd0;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_read  = is_load;
        mem_write = is_store;
        if (bus.mem_ready) begin
          wait_d = '0;
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          wait_d    = '0;
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + TMO_W'(1);
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        if (is_jal) begin
          wb_sel = 2'd2;
          pc_sel = 2'd2;
        end else if (is_load) begin
          wb_sel = 2'd1;
        end
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      opc_q     <= '0;
      f3_q      <= '0;
      f7b5_q    <= 1'b0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      f3_q      <= f3_d;
      f7b5_q    <= f7b5_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      instret_q <= instret_d;
    end
  end

  // Gate with reset so an in-flight instruction issues nothing the moment reset rises.
  assign bus.PCWrite  = pc_write  & ~reset;
  assign bus.IRWrite  = ir_write  & ~reset;
  assign bus.RegWrite = reg_write & ~reset;
  assign bus.MemRead  = mem_read  & ~reset;
  assign bus.MemWrite = mem_write & ~reset;
  assign bus.ALUSrc   = alu_src   & ~reset;
  assign bus.pc_sel   = reset ? 2'd0 : pc_sel;
  assign bus.wb_sel   = reset ? 2'd0 : wb_sel;
  assign bus.op       = reset ? 3'd0 : alu_op;
  assign bus.state    = state_q;
  assign bus.illegal  = illegal_q;
  assign bus.timeout  = timeout_q;
  assign bus.instret  = instret_q;

endmodule

// File: tb/tb_ymc_control.sv
// Directed bench for ymc_control: one instance halts on illegal opcodes, the other retires them as NOPs.
module tb_ymc_control;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  ymc_control_if #(.CNT_W(32)) bus_h ();
  ymc_control_if #(.CNT_W(32)) bus_n ();

  ymc_control #(.CNT_W(32), .TMO_W(4), .HALT_ON_ILLEGAL(1'b1)) dut_h (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_h)
  );

  ymc_control #(.CNT_W(32), .TMO_W(4), .HALT_ON_ILLEGAL(1'b0)) dut_n (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] ins, input logic zero, input logic rdy);
    bus_h.ins = ins;   bus_n.ins = ins;
    bus_h.zero = zero; bus_n.zero = zero;
    bus_h.mem_ready = rdy; bus_n.mem_ready = rdy;
    #1;
  endtask

  // Advance one clock; returns 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    set_in(32'h0, 1'b0, 1'b0);

    // Reset state, strobes forced low even though FETCH would raise IRWrite.
    chk("rst_state",   32'(bus_h.state), 32'd0);
    chk("rst_irwrite", 32'(bus_h.IRWrite), 32'd0);
    chk("rst_pcwrite", 32'(bus_h.PCWrite), 32'd0);
    chk("rst_instret", bus_h.instret, 32'd0);
    chk("rst_illegal", 32'(bus_h.illegal), 32'd0);
    chk("rst_timeout", 32'(bus_h.timeout), 32'd0);
    do_reset();

    // add x3,x1,x2
    set_in(32'h002081B3, 1'b0, 1'b0);
    chk("add_s0",    32'(bus_h.state), 32'd0);
    chk("add_ir",    32'(bus_h.IRWrite), 32'd1);
    chk("add_rw0",   32'(bus_h.RegWrite), 32'd0);
    tick();
    chk("add_s1",    32'(bus_h.state), 32'd1);
    chk("add_ir1",   32'(bus_h.IRWrite), 32'd0);
    tick();
    chk("add_s2",    32'(bus_h.state), 32'd2);
    chk("add_op",    32'(bus_h.op), 32'd2);
    chk("add_src",   32'(bus_h.ALUSrc), 32'd0);
    chk("add_rw2",   32'(bus_h.RegWrite), 32'd0);
    tick();
    chk("add_s4",    32'(bus_h.state), 32'd4);
    chk("add_rw4",   32'(bus_h.RegWrite), 32'd1);
    chk("add_pcw",   32'(bus_h.PCWrite), 32'd1);
    chk("add_wbsel", 32'(bus_h.wb_sel), 32'd0);
    chk("add_pcsel", 32'(bus_h.pc_sel), 32'd0);
    chk("add_ret0",  bus_h.instret, 32'd0);
    tick();
    chk("add_sf",    32'(bus_h.state), 32'd0);
    chk("add_ret1",  bus_h.instret, 32'd1);
    chk("add_rwf",   32'(bus_h.RegWrite), 32'd0);

    // lw x3,0(x1) with three wait cycles
    set_in(32'h0000A183, 1'b0, 1'b0);
    tick();
    tick();
    chk("lw_s2",  32'(bus_h.state), 32'd2);
    chk("lw_src", 32'(bus_h.ALUSrc), 32'd1);
    chk("lw_op",  32'(bus_h.op), 32'd2);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(32'h0000A183, 1'b0, (i == 3));
      chk("lw_mem_state", 32'(bus_h.state), 32'd3);
      chk("lw_memread",   32'(bus_h.MemRead), 32'd1);
      chk("lw_memwrite",  32'(bus_h.MemWrite), 32'd0);
      tick();
    end
    set_in(32'h0000A183, 1'b0, 1'b0);
    chk("lw_s4",    32'(bus_h.state), 32'd4);
    chk("lw_wbsel", 32'(bus_h.wb_sel), 32'd1);
    chk("lw_rw",    32'(bus_h.RegWrite), 32'd1);
    chk("lw_mr",    32'(bus_h.MemRead), 32'd0);
    tick();
    chk("lw_ret",   bus_h.instret, 32'd2);

    // beq taken then not taken
    for (int k = 0; k < 2; k++) begin
      set_in(32'h00208463, (k == 0), 1'b0);
      chk("beq_s0", 32'(bus_h.state), 32'd0);
      tick();
      chk("beq_rw1", 32'(bus_h.RegWrite), 32'd0);
      tick();
      chk("beq_s2",    32'(bus_h.state), 32'd2);
      chk("beq_pcw",   32'(bus_h.PCWrite), 32'd1);
      chk("beq_pcsel", 32'(bus_h.pc_sel), (k == 0) ? 32'd1 : 32'd0);
      chk("beq_op",    32'(bus_h.op), 32'd6);
      chk("beq_src",   32'(bus_h.ALUSrc), 32'd0);
      chk("beq_rw2",   32'(bus_h.RegWrite), 32'd0);
      tick();
      chk("beq_sf",  32'(bus_h.state), 32'd0);
      chk("beq_ret", bus_h.instret, 32'd3 + 32'(k));
    end

    // jal x1,8
    set_in(32'h008000EF, 1'b0, 1'b0);
    tick();
    tick();
    chk("jal_s2",  32'(bus_h.state), 32'd2);
    chk("jal_pcw2", 32'(bus_h.PCWrite), 32'd0);
    tick();
    chk("jal_s4",    32'(bus_h.state), 32'd4);
    chk("jal_wbsel", 32'(bus_h.wb_sel), 32'd2);
    chk("jal_pcsel", 32'(bus_h.pc_sel), 32'd2);
    chk("jal_rw",    32'(bus_h.RegWrite), 32'd1);
    tick();
    chk("jal_ret", bus_h.instret, 32'd5);

    // sw with ready arriving on the 15th memory cycle: ready wins
    set_in(32'h0020A023, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      set_in(32'h0020A023, 1'b0, (i == 14));
      chk("sw1_state", 32'(bus_h.state), 32'd3);
      chk("sw1_mw",    32'(bus_h.MemWrite), 32'd1);
      tick();
    end
    set_in(32'h0020A023, 1'b0, 1'b0);
    chk("sw1_sf",  32'(bus_h.state), 32'd0);
    chk("sw1_ret", bus_h.instret, 32'd6);
    chk("sw1_tmo", 32'(bus_h.timeout), 32'd0);

    // sw with ready never arriving: timeout after 15 wait cycles
    tick();
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("sw2_state", 32'(bus_h.state), 32'd3);
      chk("sw2_mw",    32'(bus_h.MemWrite), 32'd1);
      chk("sw2_tmo0",  32'(bus_h.timeout), 32'd0);
      tick();
    end
    chk("sw2_halt",  32'(bus_h.state), 32'd5);
    chk("sw2_tmo",   32'(bus_h.timeout), 32'd1);
    chk("sw2_mw0",   32'(bus_h.MemWrite), 32'd0);
    chk("sw2_pcw",   32'(bus_h.PCWrite), 32'd0);
    chk("sw2_ret",   bus_h.instret, 32'd6);
    set_in(32'h0020A023, 1'b0, 1'b1);
    tick();
    chk("halt_hold", 32'(bus_h.state), 32'd5);
    chk("halt_tmo",  32'(bus_h.timeout), 32'd1);

    // Illegal opcode 0x7F on both instances
    do_reset();
    chk("rst2_tmo", 32'(bus_h.timeout), 32'd0);
    set_in(32'h0000007F, 1'b0, 1'b0);
    tick();
    chk("ill_h_s1",  32'(bus_h.state), 32'd1);
    chk("ill_h_pcw", 32'(bus_h.PCWrite), 32'd0);
    chk("ill_n_pcw", 32'(bus_n.PCWrite), 32'd1);
    chk("ill_n_sel", 32'(bus_n.pc_sel), 32'd0);
    tick();
    chk("ill_h_halt", 32'(bus_h.state), 32'd5);
    chk("ill_h_flag", 32'(bus_h.illegal), 32'd1);
    chk("ill_h_ret",  bus_h.instret, 32'd0);
    chk("ill_n_s0",   32'(bus_n.state), 32'd0);
    chk("ill_n_flag", 32'(bus_n.illegal), 32'd0);
    chk("ill_n_ret",  bus_n.instret, 32'd1);
    tick();
    chk("ill_h_hold", 32'(bus_h.state), 32'd5);
    chk("ill_h_ir",   32'(bus_h.IRWrite), 32'd0);

    // Reset asserted during WB aborts the write
    do_reset();
    chk("rst3_ill", 32'(bus_h.illegal), 32'd0);
    set_in(32'h00208463, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("pre_ret", bus_h.instret, 32'd1);
    set_in(32'h002081B3, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("wb_rw", 32'(bus_h.RegWrite), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_rw",    32'(bus_h.RegWrite), 32'd0);
    chk("abort_pcw",   32'(bus_h.PCWrite), 32'd0);
    chk("abort_state", 32'(bus_h.state), 32'd0);
    chk("abort_ret",   bus_h.instret, 32'd0);
    tick();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ymc_control.md
Name: ymc_control

Overview:
- Multicycle main control unit for the yIF/yID/yEX/yDM/yWB datapath. It replaces the per-instruction combinational control decode with a registered state machine.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Supports variable-latency data memory through a ready handshake with timeout.
- Flags illegal opcodes and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- TMO_W, 4, width of memory wait counter; timeout fires at 2**TMO_W-1 wait cycles
- HALT_ON_ILLEGAL, 1, 1 = enter HALT on illegal opcode; 0 = treat it as a NOP and retire it

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ins  in  32  current instruction from the IF stage
- zero  in  1  ALU zero flag from EX
- mem_ready  in  1  data memory completes the access this cycle
- PCWrite  out  1  load PC on this edge
- pc_sel  out  2  0 = PCp4, 1 = branch, 2 = jTarget
- IRWrite  out  1  latch instruction
- RegWrite  out  1  register file write strobe
- ALUSrc  out  1  0 = rd2, 1 = imm
- wb_sel  out  2  0 = ALU z, 1 = memOut, 2 = PCp4
- MemRead  out  1  data memory read
- MemWrite  out  1  data memory write
- op  out  3  ALU operation code
- state  out  3  current state, for debug
- illegal  out  1  sticky illegal-opcode flag
- timeout  out  1  sticky memory-timeout flag
- instret  out  CNT_W  retired instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset (asynchronous, active-high):
  - state=FETCH; illegal=0, timeout=0, instret=0, wait counter=0.
  - All strobes (PCWrite, IRWrite, RegWrite, MemRead, MemWrite) are forced to 0 while reset is high.
  - pc_sel, wb_sel, ALUSrc and op are 0 during reset.
- Outputs are decoded from state plus the opcode latched at DECODE (ins[6:0]), funct3 and funct7[5].
- FETCH: IRWrite=1 -> DECODE.
- DECODE: latch opcode fields.
  - Legal opcodes: 0x33 (R), 0x13 (I-ALU), 0x03 (load), 0x23 (store), 0x63 (beq), 0x6F (jal).
  - Other opcode with HALT_ON_ILLEGAL=1: illegal<=1 -> HALT.
  - Other opcode with HALT_ON_ILLEGAL=0: PCWrite=1, pc_sel=0, instret+1 -> FETCH.
  - Legal opcode -> EXEC.
- ALU op mapping:
  - R-type: funct3 000 gives add=010, or sub=110 when funct7[5]=1.
  - funct3 111 gives and=000; 110 gives or=001; 010 gives slt=111.
  - I-ALU uses the same mapping with no sub.
  - Load/store use add=010; beq uses sub=110.
  - Unlisted funct3: op=010.
- ALUSrc=0 for R-type and beq; 1 otherwise.
- EXEC:
  - R/I -> WB; load/store -> MEM; jal -> WB.
  - beq: PCWrite=1, pc_sel=1 if zero else 0; instret+1 -> FETCH.
- MEM:
  - MemRead=1 (load) or MemWrite=1 (store), held every cycle until mem_ready=1.
  - Wait counter increments on each cycle with mem_ready=0.
  - Counter reaching 2**TMO_W-1 without ready: timeout<=1 -> HALT, with no write and no retire.
  - mem_ready=1 on a load -> WB.
  - mem_ready=1 on a store: PCWrite=1, pc_sel=0, instret+1 -> FETCH.
  - Wait counter clears on leaving MEM.
  - mem_ready in the same cycle the counter saturates: ready wins, no timeout.
- WB:
  - RegWrite=1 for exactly one cycle; PCWrite=1; instret+1 -> FETCH.
  - R/I: wb_sel=0, pc_sel=0.
  - Load: wb_sel=1, pc_sel=0.
  - jal: wb_sel=2, pc_sel=2.
- Cycles per instruction: beq 3; R/I/jal 4; store 4+waits; load 5+waits.
- HALT: all strobes 0; held until reset; illegal/timeout remain set.
- mem_ready is ignored outside MEM.
- instret wraps modulo 2**CNT_W.
- Reset asserted mid-instruction aborts it immediately; no partial RegWrite or MemWrite is issued.

Test Plan:
- add x3,x1,x2 (0x002081B3), reset released -> states 0,1,2,4; RegWrite=1 only in WB; op=010, ALUSrc=0; instret=1 after 4 cycles.
- lw (0x0000A183) with mem_ready low 3 cycles then high -> MemRead held 4 cycles; WB with wb_sel=1; retire at cycle 8.
- beq with zero=1 then zero=0 -> PCWrite in EXEC with pc_sel=1 then 0; RegWrite never asserted; 3 cycles each.
- jal (0x008000EF) -> WB with wb_sel=2, pc_sel=2, RegWrite=1.
- sw with mem_ready held 0, TMO_W=4 -> timeout=1 after 15 wait cycles; state=5; MemWrite drops; instret unchanged. Ready on the 15th cycle instead -> normal retire.
- Opcode 0x7F -> illegal=1, state=5 with HALT_ON_ILLEGAL=1; retire as NOP with 0. Assert reset in WB -> RegWrite drops immediately; state=0; instret=0.
